// File: rtl/id_branch_ctrl.sv
// id_branch_ctrl: decode-side partner of the fetch stage.
// Latches the fetched instruction and its PC+1, then decodes control-transfer
// opcodes into BS/PS/BrA/RAA for fetch. It resolves the transfer one edge later
// and squashes the single wrong-path instruction that follows a taken transfer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | no transfer outstanding; the incoming instruction always decodes
// RESOLVE | a transfer was issued last edge; its outcome is decided this edge
module id_branch_ctrl #(
  parameter int unsigned IW     = 17,
  parameter int unsigned AW     = 8,
  parameter logic [6:0]  OP_BZ  = 7'h20,
  parameter logic [6:0]  OP_BNZ = 7'h21,
  parameter logic [6:0]  OP_JMP = 7'h22,
  parameter logic [6:0]  OP_JR  = 7'h23
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] IRO,
  input  logic [AW-1:0] PC_1,
  input  logic [AW-1:0] RA,
  input  logic          Zw,
  output logic [IW-1:0] IRD,
  output logic [AW-1:0] PC_1D,
  output logic [1:0]    BS,
  output logic          PS,
  output logic [AW-1:0] BrA,
  output logic [AW-1:0] RAA,
  output logic          squash,
  output logic [15:0]   taken_cnt
);

  typedef enum logic {RUN = 1'b0, RESOLVE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ird_q, ird_d;
  logic [AW-1:0] pc_1d_q, pc_1d_d;
  logic [1:0]    bs_q, bs_d;
  logic          ps_q, ps_d;
  logic [AW-1:0] bra_q, bra_d;
  logic [AW-1:0] raa_q, raa_d;
  logic          squash_q, squash_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [6:0]        opcode;
  logic signed [7:0] off8;
  logic [AW-1:0]     target;
  logic              take;

  assign opcode = IRO[IW-1:IW-7];
  assign off8   = IRO[7:0];
  // The size cast of a signed operand sign-extends the 8-bit offset to AW.
  assign target = PC_1 + AW'(off8);

  // The registered BS/PS describe the transfer issued at the previous edge;
  // Zw is the live flag that fetch also sees.
  assign take = (state_q == RESOLVE) &&
                ((bs_q == 2'd2) || (bs_q == 2'd3) || ((bs_q == 2'd1) && (ps_q ^ Zw)));

  // State and decode registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= RUN;
      ird_q    <= '0;
      pc_1d_q  <= '0;
      bs_q     <= 2'd0;
      ps_q     <= 1'b0;
      bra_q    <= '0;
      raa_q    <= '0;
      squash_q <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      ird_q    <= ird_d;
      pc_1d_q  <= pc_1d_d;
      bs_q     <= bs_d;
      ps_q     <= ps_d;
      bra_q    <= bra_d;
      raa_q    <= raa_d;
      squash_q <= squash_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: squash the wrong-path slot on a taken transfer, otherwise decode.
  always_comb begin
    state_d  = RUN;
    ird_d    = IRO;
    pc_1d_d  = PC_1;
    bs_d     = 2'd0;
    ps_d     = 1'b0;
    bra_d    = '0;
    raa_d    = '0;
    squash_d = 1'b0;
    cnt_d    = cnt_q;
    if (take) begin
      // Whatever sits in this slot, including a transfer opcode, is discarded.
      ird_d    = '0;
      squash_d = 1'b1;
      cnt_d    = cnt_q + 16'd1;
    end else begin
      unique case (opcode)
        OP_BZ: begin
          bs_d    = 2'd1;
          bra_d   = target;
          state_d = RESOLVE;
        end
        OP_BNZ: begin
          bs_d    = 2'd1;
          ps_d    = 1'b1;
          bra_d   = target;
          state_d = RESOLVE;
        end
        OP_JMP: begin
          bs_d    = 2'd3;
          bra_d   = target;
          state_d = RESOLVE;
        end
        OP_JR: begin
          bs_d    = 2'd2;
          raa_d   = RA;
          state_d = RESOLVE;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Outputs come straight from registers so fetch sees stable values at its falling edge.
  always_comb begin
    IRD       = ird_q;
    PC_1D     = pc_1d_q;
    BS        = bs_q;
    PS        = ps_q;
    BrA       = bra_q;
    RAA       = raa_q;
    squash    = squash_q;
    taken_cnt = cnt_q;
  end

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Directed bench for id_branch_ctrl: inputs change on the falling edge,
// outputs are checked 1 ns after the rising edge.
module tb_id_branch_ctrl;

  localparam int IW = 17;
  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic [IW-1:0] IRO;
  logic [AW-1:0] PC_1;
  logic [AW-1:0] RA;
  logic          Zw;
  logic [IW-1:0] IRD;
  logic [AW-1:0] PC_1D;
  logic [1:0]    BS;
  logic          PS;
  logic [AW-1:0] BrA;
  logic [AW-1:0] RAA;
  logic          squash;
  logic [15:0]   taken_cnt;

  int total;
  int bad;

  id_branch_ctrl dut (
    .clk(clk), .reset(reset), .IRO(IRO), .PC_1(PC_1), .RA(RA), .Zw(Zw),
    .IRD(IRD), .PC_1D(PC_1D), .BS(BS), .PS(PS), .BrA(BrA), .RAA(RAA),
    .squash(squash), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk(input logic [6:0] op, input logic [7:0] off);
    return {op, 2'b00, off};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [IW-1:0] iro, input logic [AW-1:0] pc,
                      input logic [AW-1:0] ra, input logic zw);
    @(negedge clk);
    reset = rst; IRO = iro; PC_1 = pc; RA = ra; Zw = zw;
    @(posedge clk);
    #1;
  endtask

  // Checks every output against a full expected set.
  task automatic chk_all(input string tag, input logic [IW-1:0] ird, input logic [AW-1:0] pcd,
                         input logic [1:0] bs, input logic ps, input logic [AW-1:0] bra,
                         input logic [AW-1:0] raa, input logic sq, input logic [15:0] cnt);
    chk({tag, ".IRD"}, 32'(IRD), 32'(ird));
    chk({tag, ".PC_1D"}, 32'(PC_1D), 32'(pcd));
    chk({tag, ".BS"}, 32'(BS), 32'(bs));
    chk({tag, ".PS"}, 32'(PS), 32'(ps));
    chk({tag, ".BrA"}, 32'(BrA), 32'(bra));
    chk({tag, ".RAA"}, 32'(RAA), 32'(raa));
    chk({tag, ".squash"}, 32'(squash), 32'(sq));
    chk({tag, ".cnt"}, 32'(taken_cnt), 32'(cnt));
  endtask

  localparam logic [6:0] BZ  = 7'h20;
  localparam logic [6:0] BNZ = 7'h21;
  localparam logic [6:0] JMP = 7'h22;
  localparam logic [6:0] JR  = 7'h23;
  localparam logic [6:0] ADD = 7'h01;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0; IRO = mk(JMP, 8'h10); PC_1 = 8'h40; RA = 8'h55; Zw = 1'b0;

    // Reset held for two edges with a JMP presented.
    step(1'b0, mk(JMP, 8'h10), 8'h40, 8'h55, 1'b0);
    step(1'b0, mk(JMP, 8'h10), 8'h41, 8'h55, 1'b0);
    chk_all("reset", '0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0);

    // First instruction after release decodes normally.
    step(1'b1, mk(ADD, 8'h33), 8'h10, 8'h00, 1'b0);
    chk_all("rel_add", mk(ADD, 8'h33), 8'h10, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0);

    // JMP 05 + (-2) = 03, then squash.
    step(1'b1, mk(JMP, 8'hFE), 8'h05, 8'h00, 1'b0);
    chk_all("jmp", mk(JMP, 8'hFE), 8'h05, 2'd3, 1'b0, 8'h03, 8'h00, 1'b0, 16'd0);
    step(1'b1, mk(ADD, 8'h44), 8'h06, 8'h00, 1'b0);
    chk_all("jmp_sq", '0, 8'h06, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 16'd1);

    // BZ FF + 2 wraps to 01; Zw=1 takes it.
    step(1'b1, mk(BZ, 8'h02), 8'hFF, 8'h00, 1'b0);
    chk_all("bz1", mk(BZ, 8'h02), 8'hFF, 2'd1, 1'b0, 8'h01, 8'h00, 1'b0, 16'd1);
    step(1'b1, mk(ADD, 8'h01), 8'h00, 8'h00, 1'b1);
    chk_all("bz1_sq", '0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 16'd2);

    // Same BZ with Zw=0: falls through, count unchanged.
    step(1'b1, mk(BZ, 8'h02), 8'hFF, 8'h00, 1'b1);
    chk_all("bz2", mk(BZ, 8'h02), 8'hFF, 2'd1, 1'b0, 8'h01, 8'h00, 1'b0, 16'd2);
    step(1'b1, mk(ADD, 8'h02), 8'h00, 8'h00, 1'b0);
    chk_all("bz2_nt", mk(ADD, 8'h02), 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 16'd2);

    // JR to A7, then squash; the JMP in the squashed slot is discarded.
    step(1'b1, mk(JR, 8'h77), 8'h20, 8'hA7, 1'b0);
    chk_all("jr", mk(JR, 8'h77), 8'h20, 2'd2, 1'b0, 8'h00, 8'hA7, 1'b0, 16'd2);
    step(1'b1, mk(JMP, 8'h04), 8'h21, 8'h11, 1'b0);
    chk_all("jr_sq", '0, 8'h21, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 16'd3);
    step(1'b1, mk(ADD, 8'h05), 8'hA8, 8'h00, 1'b0);
    chk_all("after_sq", mk(ADD, 8'h05), 8'hA8, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 16'd3);

    // BNZ not taken (Zw=1) followed by a JMP that decodes and is then taken.
    step(1'b1, mk(BNZ, 8'h10), 8'h30, 8'h00, 1'b0);
    chk_all("bnz", mk(BNZ, 8'h10), 8'h30, 2'd1, 1'b1, 8'h40, 8'h00, 1'b0, 16'd3);
    step(1'b1, mk(JMP, 8'h80), 8'h31, 8'h00, 1'b1);
    chk_all("bnz_jmp", mk(JMP, 8'h80), 8'h31, 2'd3, 1'b0, 8'hB1, 8'h00, 1'b0, 16'd3);
    step(1'b1, mk(ADD, 8'h06), 8'h32, 8'h00, 1'b1);
    chk_all("bnz_jmp_sq", '0, 8'h32, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 16'd4);

    // BNZ taken (Zw=0).
    step(1'b1, mk(BNZ, 8'h7F), 8'h81, 8'h00, 1'b1);
    chk_all("bnz_t", mk(BNZ, 8'h7F), 8'h81, 2'd1, 1'b1, 8'h00, 8'h00, 1'b0, 16'd4);
    step(1'b1, mk(ADD, 8'h07), 8'h82, 8'h00, 1'b0);
    chk_all("bnz_t_sq", '0, 8'h82, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 16'd5);

    // JMP issued, reset on the next edge cancels the pending resolve.
    step(1'b1, mk(JMP, 8'h02), 8'h50, 8'h00, 1'b0);
    chk_all("jmp_rst", mk(JMP, 8'h02), 8'h50, 2'd3, 1'b0, 8'h52, 8'h00, 1'b0, 16'd5);
    step(1'b0, mk(ADD, 8'h08), 8'h51, 8'h00, 1'b0);
    chk_all("rst2", '0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0);
    step(1'b1, mk(ADD, 8'h09), 8'h60, 8'h00, 1'b0);
    chk_all("rst2_rel", mk(ADD, 8'h09), 8'h60, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
